bel_avl_frame_dma: RTL
======================

# bel_avl_frame_dma

Avalon-MM master that sits directly in front of the FFT working RAM (`bel_avl_ram` port). It writes one frame of streamed audio samples into the RAM as complex words with zero imaginary part, pulses the FFT start, and waits for FFT done. It then reads the first `out_bins` result words back and streams out their L1 magnitudes (|re| + |im|) to the visualizer.

## Interface
- `size`, 64: frame length in words; must be a power of two, at least 4.
- `adr_width`, 6: RAM address width; `2**adr_width` equals `size`.
- `out_bins`, 32: number of result bins streamed out (addresses 0 .. out_bins-1); 1 ≤ out_bins ≤ size.
- `` `BEL_FFT_DWIDTH ``, from `bel_fft_def.v`: complex word width W. Real part is `[W-1:W/2]`, imaginary part is `[W/2-1:0]`, both two's complement. H = W/2.

Ports:
- `clk_i`  in  1  clock; the block has one clock domain.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `smp_data_i`  in  H  signed audio sample.
- `smp_valid_i`  in  1  sample valid.
- `smp_ready_o`  out  1  block accepts a sample this cycle.
- `fft_start_o`  out  1  one-cycle pulse: frame loaded, start FFT.
- `fft_done_i`  in  1  FFT finished; level or pulse.
- `address_o`  out  adr_width  Avalon address.
- `writedata_o`  out  W  Avalon write data.
- `write_o`  out  1  Avalon write strobe.
- `read_o`  out  1  Avalon read strobe.
- `readdata_i`  in  W  Avalon read data; valid only while `readdatavalid_i` is 1.
- `readdatavalid_i`  in  1  read data valid.
- `mag_data_o`  out  H+1  unsigned L1 magnitude.
- `mag_index_o`  out  adr_width  bin index of `mag_data_o`.
- `mag_valid_o`  out  1  magnitude valid.
- `mag_ready_i`  in  1  consumer accepts the magnitude.
- `busy_o`  out  1  high in every state except LOAD.

## Operation
- States: LOAD, START, WAIT_FFT, RD_REQ, RD_WAIT, OUT. Reset enters LOAD with the index counter `idx` at 0.
- **LOAD**
  - `smp_ready_o` = 1 while `idx` < size.
  - Each accepted sample (valid & ready) registers:
    - `write_o` = 1
    - `address_o` = idx
    - `writedata_o` = {sample, H'b0}
  - `idx` then increments.
  - When sample size-1 is accepted, `smp_ready_o` drops and the state moves to START.
- **START**: drives `fft_start_o` = 1 for exactly one cycle, clears `idx`, then goes to WAIT_FFT.
- **WAIT_FFT**: waits for `fft_done_i` = 1, then goes to RD_REQ. `fft_done_i` is ignored in every other state.
- **RD_REQ**: drives `read_o` = 1 with `address_o` = idx for one cycle, then goes to RD_WAIT.
- **RD_WAIT**: waits for `readdatavalid_i`. On that cycle the block registers:
  - `mag_data_o` = |re| + |im|, each absolute value computed at H+1 bits. Example: -32768 gives 32768; the maximum result is 65536.
  - `mag_index_o` = idx
  - `mag_valid_o` = 1
  - The state moves to OUT.
- **OUT**:
  - `mag_valid_o`, `mag_data_o` and `mag_index_o` are held stable until `mag_ready_i` = 1.
  - On that handshake, `mag_valid_o` clears.
  - If idx = out_bins-1, the block clears `idx` and returns to LOAD. Otherwise `idx` increments and the state returns to RD_REQ.
- `read_o` and `write_o` are never high in the same cycle.
- `smp_ready_o` = 0 in every state other than LOAD; samples presented then are not consumed.

## Timing
- Reset values: every output is 0, including `smp_ready_o`. `smp_ready_o` rises on the first clock edge after `rst_n_i` deasserts.
- Load throughput is one sample per cycle. A sample accepted at edge N appears as a write in cycle N+1.
- `fft_start_o` is asserted the cycle after the last write.
- Read loop per bin: RD_REQ (1 cycle), RD_WAIT (≥1 cycle), OUT (≥1 cycle). With a 1-cycle RAM and `mag_ready_i` tied to 1, one bin completes every 3 cycles.
- `readdatavalid_i` arriving outside RD_WAIT is ignored.
- Reset asserted mid-frame aborts immediately: outputs drop to 0 asynchronously and the partial frame is discarded. After release the block restarts in LOAD at address 0.

## Test plan
- **Load path.** Reset, then stream samples 0x0001..0x0040 back-to-back (size=64, W=32).
  - Required: 64 writes at addresses 0..63 with data `{smp,0000}`.
  - Required: `fft_start_o` is a single pulse one cycle after write 63.
  - Required: `smp_ready_o` = 0 afterwards.
- **Backpressure on input.** Drive `smp_valid_i` toggling 1/0.
  - Required: writes occur only after accepted samples, with addresses still contiguous 0..63.
- **Magnitude arithmetic.** Preload RAM words 0x8000_8000, 0x7FFF_0001 and 0xFFFF_FFFF at bins 0..2.
  - Required: `mag_data_o` = 65536, 32768 and 2 respectively, with `mag_index_o` = 0, 1 and 2.
- **Output stall.** Hold `mag_ready_i` = 0 for 10 cycles on bin 5.
  - Required: `mag_valid_o`, `mag_data_o` and `mag_index_o` stay constant.
  - Required: no `read_o` is issued until the handshake completes.
- **Frame wrap.** After bin 31 handshakes, the block returns to LOAD: `smp_ready_o` = 1 next cycle and the next write goes to address 0.
- **Reset mid-readout.** Assert `rst_n_i` = 0 while in RD_WAIT.
  - Required: all outputs go to 0 without waiting for a clock.
  - Required: after release, the block starts a new load at address 0.

Source files
------------

// File: rtl/bel_avl_frame_dma.sv
// Frame DMA in front of the FFT working RAM: loads one frame of samples as complex words,
// kicks the FFT, then reads back the first out_bins results and streams their L1 magnitudes.
`ifndef BEL_FFT_DWIDTH
`define BEL_FFT_DWIDTH 32
`endif

module bel_avl_frame_dma #(
  parameter int size      = 64,
  parameter int adr_width = 6,
  parameter int out_bins  = 32,
  parameter int DATA_W    = `BEL_FFT_DWIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic signed [DATA_W/2-1:0] smp_data_i,
  input  logic                       smp_valid_i,
  output logic                       smp_ready_o,
  output logic                       fft_start_o,
  input  logic                       fft_done_i,
  output logic [adr_width-1:0]       address_o,
  output logic [DATA_W-1:0]          writedata_o,
  output logic                       write_o,
  output logic                       read_o,
  input  logic [DATA_W-1:0]          readdata_i,
  input  logic                       readdatavalid_i,
  output logic [DATA_W/2:0]          mag_data_o,
  output logic [adr_width-1:0]       mag_index_o,
  output logic                       mag_valid_o,
  input  logic                       mag_ready_i,
  output logic                       busy_o
);
  localparam int H = DATA_W / 2;
  localparam logic [adr_width-1:0] LAST_SMP = adr_width'(size - 1);
  localparam logic [adr_width-1:0] LAST_BIN = adr_width'(out_bins - 1);
  localparam logic [adr_width-1:0] IDX_ONE  = adr_width'(1);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_WAIT_FFT, S_RD_REQ, S_RD_WAIT, S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [adr_width-1:0]   idx_q, idx_d;
  logic                   ready_q, ready_d;
  logic                   write_q, write_d;
  logic [adr_width-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   start_q, start_d;
  logic [H:0]             mag_data_q, mag_data_d;
  logic [adr_width-1:0]   mag_index_q, mag_index_d;
  logic                   mag_valid_q, mag_valid_d;

  // Absolute value widened by one bit so the most negative input stays exact.
  function automatic logic [H:0] abs_ext(input logic signed [H-1:0] v);
    logic signed [H:0] e;
    e = {v[H-1], v};
    return e[H] ? -e : e;
  endfunction

  // |re| + |im| never exceeds 2**H, so it fits in H+1 bits without saturation.
  function automatic logic [H:0] l1_mag(input logic [DATA_W-1:0] w);
    return abs_ext(w[DATA_W-1:H]) + abs_ext(w[H-1:0]);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ready_d     = ready_q;
    write_d     = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    start_d     = 1'b0;
    mag_data_d  = mag_data_q;
    mag_index_d = mag_index_q;
    mag_valid_d = mag_valid_q;
    case (state_q)
      S_LOAD: begin
        ready_d = 1'b1;
        if (smp_valid_i && ready_q) begin
          write_d = 1'b1;
          waddr_d = idx_q;
          wdata_d = {smp_data_i, {H{1'b0}}};
          if (idx_q == LAST_SMP) begin
            idx_d   = '0;
            ready_d = 1'b0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_START: begin
        start_d = 1'b1;
        idx_d   = '0;
        state_d = S_WAIT_FFT;
      end
      S_WAIT_FFT: if (fft_done_i) state_d = S_RD_REQ;
      S_RD_REQ:   state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (readdatavalid_i) begin
          mag_data_d  = l1_mag(readdata_i);
          mag_index_d = idx_q;
          mag_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (mag_ready_i) begin
          mag_valid_d = 1'b0;
          if (idx_q == LAST_BIN) begin
            idx_d   = '0;
            ready_d = 1'b1;
            state_d = S_LOAD;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_RD_REQ;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Every output-facing flop is cleared so an aborted frame leaves the bus idle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      start_q     <= 1'b0;
      mag_data_q  <= '0;
      mag_index_q <= '0;
      mag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      start_q     <= start_d;
      mag_data_q  <= mag_data_d;
      mag_index_q <= mag_index_d;
      mag_valid_q <= mag_valid_d;
    end
  end

  assign smp_ready_o = ready_q;
  assign fft_start_o = start_q;
  assign read_o      = (state_q == S_RD_REQ);
  assign address_o   = (state_q == S_RD_REQ) ? idx_q : waddr_q;
  assign writedata_o = wdata_q;
  assign write_o     = write_q;
  assign mag_data_o  = mag_data_q;
  assign mag_index_o = mag_index_q;
  assign mag_valid_o = mag_valid_q;
  assign busy_o      = (state_q != S_LOAD);

endmodule
